// File: rtl/bsw_max_tracker_pkg.sv
// Shared types and defaults for the banded Smith-Waterman max tracker.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package bsw_max_tracker_pkg;

  localparam int NUM_PE_DEF = 8;
  localparam int H_W_DEF    = 7;
  localparam int CYC_W_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Lane-index width; a single-lane array still needs one bit.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsw_max_tracker_if.sv
// Beat/result bundle between the PE array side and the max tracker.
// Latency: n/a (wires only).
// Backpressure: none; the tracker accepts one anti-diagonal every RUN cycle.
interface bsw_max_tracker_if
  import bsw_max_tracker_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int H_W    = H_W_DEF,
  parameter int CYC_W  = CYC_W_DEF
);
  localparam int LANE_W = lane_w(NUM_PE);

  logic                    start;
  logic [NUM_PE-1:0]       h_valid;
  logic [NUM_PE*H_W-1:0]   h_vec;
  logic                    h_last;
  logic                    busy;
  logic                    done;
  logic                    result_valid;
  logic [H_W-1:0]          best_score;
  logic [LANE_W-1:0]       best_lane;
  logic [CYC_W-1:0]        best_cyc;

  modport master (
    output start, h_valid, h_vec, h_last,
    input  busy, done, result_valid, best_score, best_lane, best_cyc
  );

  modport slave (
    input  start, h_valid, h_vec, h_last,
    output busy, done, result_valid, best_score, best_lane, best_cyc
  );
endinterface

// File: rtl/bsw_max_tracker_argmax_tree.sv
// Combinational NUM_PE-way argmax over one anti-diagonal, invalid lanes read as 0.
// Latency: 0 cycles (pure combinational, registered by the caller).
// Backpressure: none.
module bsw_max_tracker_argmax_tree #(
  parameter int NUM_PE = 8,
  parameter int H_W    = 7,
  parameter int LANE_W = 3
) (
  input  logic [NUM_PE-1:0]     h_valid,
  input  logic [NUM_PE*H_W-1:0] h_vec,
  output logic [H_W-1:0]        max_score,
  output logic [LANE_W-1:0]     max_lane
);

  logic [H_W-1:0] lane_score;

  // Scan upward with a strict compare so the lowest lane keeps a tie.
  always_comb begin
    max_score  = '0;
    max_lane   = '0;
    lane_score = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      lane_score = h_valid[p] ? h_vec[p*H_W +: H_W] : '0;
      if (lane_score > max_score) begin
        max_score = lane_score;
        max_lane  = LANE_W'(p);
      end
    end
  end

endmodule

// File: rtl/bsw_max_tracker.sv
// Tracks best H score, lane and anti-diagonal index over one alignment run.
// Latency: beat -> best_* two edges later; done pulses two edges after the h_last beat.
// Backpressure: none; every RUN cycle is a beat, start is ignored while busy.
module bsw_max_tracker
  import bsw_max_tracker_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int H_W    = H_W_DEF,
  parameter int CYC_W  = CYC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  bsw_max_tracker_if.slave  bus
);

  localparam int              LANE_W  = lane_w(NUM_PE);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  state_t            state, state_nxt;
  logic              run_beat;
  logic              start_ok;
  logic              done_q;
  logic [CYC_W-1:0]  cnt;

  logic [H_W-1:0]    am_score;
  logic [LANE_W-1:0] am_lane;

  logic              s1_vld;
  logic [H_W-1:0]    s1_score;
  logic [LANE_W-1:0] s1_lane;
  logic [CYC_W-1:0]  s1_cyc;

  logic [H_W-1:0]    best_score;
  logic [LANE_W-1:0] best_lane;
  logic [CYC_W-1:0]  best_cyc;

  assign run_beat = (state == ST_RUN);
  assign start_ok = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

  bsw_max_tracker_argmax_tree #(
    .NUM_PE (NUM_PE),
    .H_W    (H_W),
    .LANE_W (LANE_W)
  ) u_argmax (
    .h_valid   (bus.h_valid),
    .h_vec     (bus.h_vec),
    .max_score (am_score),
    .max_lane  (am_lane)
  );

  // State register; done is a one-cycle flag for the DRAIN->DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == ST_DRAIN);
    end
  end

  // Next-state: start only leaves IDLE/DONE, h_last only counts inside RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_RUN;
      ST_RUN:   if (bus.h_last) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  if (bus.start) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    bus.busy         = (state == ST_RUN) || (state == ST_DRAIN);
    bus.result_valid = (state == ST_DONE);
    bus.done         = done_q;
  end

  // Beat counter: cleared on accepted start, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start_ok) begin
      cnt <= '0;
    end else if (run_beat && (cnt != CYC_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stage 1: capture the per-beat winner together with its beat index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_score <= '0;
      s1_lane  <= '0;
      s1_cyc   <= '0;
    end else begin
      s1_vld <= run_beat;
      if (run_beat) begin
        s1_score <= am_score;
        s1_lane  <= am_lane;
        s1_cyc   <= cnt;
      end
    end
  end

  // Stage 2: strict running max, so the earliest beat keeps a tie and 0 never wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_score <= '0;
      best_lane  <= '0;
      best_cyc   <= '0;
    end else if (start_ok) begin
      best_score <= '0;
      best_lane  <= '0;
      best_cyc   <= '0;
    end else if (s1_vld && (s1_score > best_score)) begin
      best_score <= s1_score;
      best_lane  <= s1_lane;
      best_cyc   <= s1_cyc;
    end
  end

  assign bus.best_score = best_score;
  assign bus.best_lane  = best_lane;
  assign bus.best_cyc   = best_cyc;

endmodule
